exec_mem_model: RTL
===================

Name: exec_mem_model

Overview:
- Parametrised, storage-backed memory model for EXEC unit-level validation of the PDP-8 datapath.
- Replaces a stateless random-data responder with a real word array and read-after-write coherence.
- Adds a configurable read latency, an explicit read-valid strobe, and deterministic pseudo-random data for unwritten locations.
- Sits beside the EXEC DUT in the unit testbench and serves the EXEC read and write ports.

Parameters:
- ADDR_WIDTH, 12 (`ADDR_WIDTH): address bits; the array holds 2**ADDR_WIDTH words.
- DATA_WIDTH, 12 (`DATA_WIDTH): word width; legal range 1..16.
- RD_LATENCY, 1: cycles from read request to exec_rd_valid; legal range 1..4.
- INIT_MODE, INIT_LFSR: INIT_ZERO makes unwritten words read as 0; INIT_LFSR makes them read as LFSR data.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock; all activity on the rising edge.
- reset  in  1  synchronous, active-high reset.
- exec_rd_req  in  1  read request, sampled each cycle.
- exec_rd_addr  in  ADDR_WIDTH  read address, sampled with exec_rd_req.
- exec_rd_data  out  DATA_WIDTH  read data; holds its value between valids.
- exec_rd_valid  out  1  one-cycle strobe marking exec_rd_data as valid.
- exec_wr_req  in  1  write request.
- exec_wr_addr  in  ADDR_WIDTH  write address.
- exec_wr_data  in  DATA_WIDTH  write data.
- rd_count  out  16  number of accepted reads; wraps.
- wr_count  out  16  number of accepted writes; wraps.

Behaviour:
- **Clock and reset:** one clock, clk. Reset is synchronous and active-high.
- **Reset state** (on any edge where reset=1):
  - exec_rd_data=0, exec_rd_valid=0, rd_count=0, wr_count=0.
  - All pipeline valid bits cleared.
  - All per-word written flags cleared; array contents are don't-care.
  - LFSR loaded with LFSR_SEED.
  - Requests on reset edges are ignored and not counted.
- **Write:** on an edge with exec_wr_req=1: mem[wr_addr]<=wr_data, written[wr_addr]<=1, wr_count++.
- **Read accept:** on an edge with exec_rd_req=1, the lookup happens at that edge and the result enters pipeline stage 1. rd_count++.
- **Read result:**
  - Same-cycle write to the same address: return exec_wr_data (write-first bypass).
  - Else if written[addr]=1: return mem[addr].
  - Else, INIT_ZERO: return 0; nothing is stored.
  - Else, INIT_LFSR: return LFSR[DATA_WIDTH-1:0]. Store that value in mem[addr] and set written[addr]=1, so repeat reads are stable. Advance the LFSR one step.
  - An LFSR fill never overrides a same-edge write to the same address; the write wins.
- **LFSR:** 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifting left, new bit into bit 0. It advances only on unwritten reads in INIT_LFSR mode.
- **Latency:** the request at edge N gives exec_rd_valid=1 and the new exec_rd_data visible after edge N+RD_LATENCY. exec_rd_data updates only on valid edges; otherwise it holds.
- **Throughput:** one read per cycle, fully pipelined. Back-to-back requests give back-to-back valids in order. A read and a write may both occur on every cycle.
- **Read-after-write:** a write at edge N is visible to any read accepted at edge N (bypass) or later.
- **Reset mid-operation:** in-flight reads are discarded and no valid is issued for them. The first valid after reset deasserts comes from a request accepted after reset.
- **Address coverage:** every address is in range; no bounds checking is needed.
- **Counters:** 16-bit, wrap from FFFF to 0000.

Decomposition:
- pdp8_pkg additions:
  - typedef enum logic {INIT_ZERO, INIT_LFSR} mem_init_mode_e.
  - localparam MEM_LFSR_WIDTH=16.
  - localparam MEM_LFSR_TAPS=16'hB400.
  - localparam MEM_MAX_RD_LATENCY=4.
- Sub-module mem_model_lfsr, with ports clk, reset, advance, seed, value[15:0].
- Top level contains the array, the written-flag vector, the read pipeline shift register (data+valid per stage) and the counters.

Test Plan:
- **Reset:** assert reset 2 cycles with rd_req=1 -> rd_valid stays 0, exec_rd_data=0, rd_count=0.
- **Write then read:** write 12'h5A5 to addr 12'o0200, then read 12'o0200 with RD_LATENCY=3 -> valid exactly 3 edges later, data 12'h5A5, rd_count=1, wr_count=1.
- **Same-edge bypass:** read and write of 12'h777 to addr 12'h010 on the same edge -> returned data is 12'h777.
- **Unwritten read, INIT_LFSR, seed ACE1:** the first read of addr 12'h123 returns ACE1[11:0]=12'hCE1. A second read of 12'h123 returns 12'hCE1 again. A read of addr 12'h124 returns the next LFSR value (shifted seed, masked to 12 bits).
- **Streaming:** 8 consecutive reads of addresses 0..7 preloaded with 12'h100+i, RD_LATENCY=2 -> 8 consecutive valid cycles, in-order data 12'h100..12'h107.
- **Reset in flight:** with RD_LATENCY=4, issue 3 reads, assert reset 1 cycle before the first valid -> no valid appears, and written flags clear. A read of an INIT_ZERO build then returns 0.

Source files
------------

// File: rtl/exec_mem_model_pkg.sv
// exec_mem_model_pkg: shared types and constants for the EXEC memory model.
//   mem_init_mode_e    - what an unwritten word reads as (zero or LFSR data)
//   MEM_LFSR_WIDTH     - width of the fill-data LFSR
//   MEM_LFSR_TAPS      - feedback mask for x^16+x^14+x^13+x^11+1 (shift-left form)
//   MEM_MAX_RD_LATENCY - largest supported read latency
//   mem_lfsr_step()    - one Fibonacci step of the fill LFSR
package exec_mem_model_pkg;

  typedef enum logic {INIT_ZERO, INIT_LFSR} mem_init_mode_e;

  localparam int unsigned MEM_LFSR_WIDTH = 16;
  localparam logic [MEM_LFSR_WIDTH-1:0] MEM_LFSR_TAPS = 16'hB400;
  localparam int unsigned MEM_MAX_RD_LATENCY = 4;

  // Shift left, parity of the tapped bits enters at bit 0.
  function automatic logic [MEM_LFSR_WIDTH-1:0] mem_lfsr_step(
    input logic [MEM_LFSR_WIDTH-1:0] cur
  );
    return {cur[MEM_LFSR_WIDTH-2:0], ^(cur & MEM_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/exec_mem_if.sv
// exec_mem_if: EXEC read/write port bundle between the EXEC datapath and its memory.
//   master modport - EXEC side: drives requests, addresses and write data
//   slave modport  - memory side: returns exec_rd_data / exec_rd_valid
interface exec_mem_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 12
);

  logic                  exec_rd_req;
  logic [ADDR_WIDTH-1:0] exec_rd_addr;
  logic [DATA_WIDTH-1:0] exec_rd_data;
  logic                  exec_rd_valid;
  logic                  exec_wr_req;
  logic [ADDR_WIDTH-1:0] exec_wr_addr;
  logic [DATA_WIDTH-1:0] exec_wr_data;

  modport master (
    output exec_rd_req,
    output exec_rd_addr,
    output exec_wr_req,
    output exec_wr_addr,
    output exec_wr_data,
    input  exec_rd_data,
    input  exec_rd_valid
  );

  modport slave (
    input  exec_rd_req,
    input  exec_rd_addr,
    input  exec_wr_req,
    input  exec_wr_addr,
    input  exec_wr_data,
    output exec_rd_data,
    output exec_rd_valid
  );

endinterface

// File: rtl/exec_mem_model_lfsr.sv
// exec_mem_model_lfsr: 16-bit Fibonacci LFSR supplying data for unwritten words.
//   clk     - clock
//   reset   - synchronous active-high reset, loads seed
//   advance - step the register once on this edge
//   seed    - reset value (must be nonzero)
//   value   - current register contents
module exec_mem_model_lfsr
  import exec_mem_model_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      advance,
  input  logic [MEM_LFSR_WIDTH-1:0] seed,
  output logic [MEM_LFSR_WIDTH-1:0] value
);

  logic [MEM_LFSR_WIDTH-1:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= seed;
    end else if (advance) begin
      lfsr_q <= mem_lfsr_step(lfsr_q);
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/exec_mem_model.sv
// exec_mem_model: storage-backed memory model serving the EXEC read and write ports.
//   clk      - clock, all activity on the rising edge
//   reset    - synchronous active-high reset
//   mem_bus  - exec_mem_if slave: read request/address in, read data/valid out,
//              write request/address/data in
//   rd_count - accepted reads, 16-bit wrapping
//   wr_count - accepted writes, 16-bit wrapping
// Reads look up at the request edge and emerge RD_LATENCY edges later as a one-cycle
// valid strobe; exec_rd_data holds between strobes. Unwritten words read as zero or as
// LFSR data, which is then stored so repeat reads are stable.
module exec_mem_model
  import exec_mem_model_pkg::*;
#(
  parameter int unsigned    ADDR_WIDTH = 12,
  parameter int unsigned    DATA_WIDTH = 12,
  parameter int unsigned    RD_LATENCY = 1,
  parameter mem_init_mode_e INIT_MODE  = INIT_LFSR,
  parameter logic [15:0]    LFSR_SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  exec_mem_if.slave         mem_bus,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [Depth-1:0]      written_q;

  logic                      rd_fire;
  logic                      wr_fire;
  logic                      bypass;
  logic                      fill;
  logic [DATA_WIDTH-1:0]     lookup_data;
  logic [MEM_LFSR_WIDTH-1:0] lfsr_value;
  logic                      lfsr_unused_bits;

  logic [15:0] rd_count_q;
  logic [15:0] wr_count_q;

  // Stage 0 captures the lookup at the request edge; stage RD_LATENCY drives the port.
  logic [RD_LATENCY:0]   pipe_valid_q;
  logic [DATA_WIDTH-1:0] pipe_data_q [RD_LATENCY+1];

  exec_mem_model_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (fill),
    .seed    (LFSR_SEED),
    .value   (lfsr_value)
  );

  // Only the low DATA_WIDTH bits feed the array; the rest exist for the sequence itself.
  assign lfsr_unused_bits = ^(lfsr_value >> DATA_WIDTH);

  always_comb begin
    rd_fire     = mem_bus.exec_rd_req & ~reset;
    wr_fire     = mem_bus.exec_wr_req & ~reset;
    bypass      = wr_fire && (mem_bus.exec_wr_addr == mem_bus.exec_rd_addr);
    fill        = 1'b0;
    lookup_data = mem_q[mem_bus.exec_rd_addr];
    if (bypass) begin
      lookup_data = mem_bus.exec_wr_data;
    end else if (!written_q[mem_bus.exec_rd_addr]) begin
      if (INIT_MODE == INIT_LFSR) begin
        lookup_data = lfsr_value[DATA_WIDTH-1:0];
        fill        = rd_fire;
      end else begin
        lookup_data = '0;
      end
    end
  end

  // Array contents are don't-care after reset; the written flags decide what is real.
  // fill is never set for the write address, so the two ports never collide.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[mem_bus.exec_wr_addr] <= mem_bus.exec_wr_data;
    end
    if (fill) begin
      mem_q[mem_bus.exec_rd_addr] <= lfsr_value[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      written_q <= '0;
    end else begin
      if (wr_fire) begin
        written_q[mem_bus.exec_wr_addr] <= 1'b1;
      end
      if (fill) begin
        written_q[mem_bus.exec_rd_addr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid_q[0] <= 1'b0;
      pipe_data_q[0]  <= '0;
    end else begin
      pipe_valid_q[0] <= rd_fire;
      if (rd_fire) begin
        pipe_data_q[0] <= lookup_data;
      end
    end
  end

  // Data only moves with its valid bit, so the last stage naturally holds between strobes.
  for (genvar k = 1; k <= int'(RD_LATENCY); k++) begin : g_stage
    always_ff @(posedge clk) begin
      if (reset) begin
        pipe_valid_q[k] <= 1'b0;
        pipe_data_q[k]  <= '0;
      end else begin
        pipe_valid_q[k] <= pipe_valid_q[k-1];
        if (pipe_valid_q[k-1]) begin
          pipe_data_q[k] <= pipe_data_q[k-1];
        end
      end
    end
  end

  assign mem_bus.exec_rd_valid = pipe_valid_q[RD_LATENCY];
  assign mem_bus.exec_rd_data  = pipe_data_q[RD_LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      if (rd_fire) begin
        rd_count_q <= rd_count_q + 16'd1;
      end
      if (wr_fire) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

endmodule
